// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file slice.
// The optional REGFILE_BYPASS_EN write-to-read forwarding lives in regfile_sb.
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREG  = 16;
    localparam int DEF_NRD   = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // The highest architectural index is the PC slot; it has no storage.
    function automatic int pc_slot(input int nreg);
        return nreg - 1;
    endfunction

    localparam int R15_IDX = pc_slot(DEF_NREG);

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard: one busy bit per storage entry plus a
// registered population count of those bits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    localparam int AW  = clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we3,
    input  logic [AW-1:0]   a3,
    input  logic            issue,
    input  logic [AW-1:0]   issue_a,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     pend_cnt
);

    localparam int PC = pc_slot(NREG);

    logic [NREG-1:0] busy_next;
    logic [AW:0]     cnt_next;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        busy_next = busy;
        cnt_next  = '0;
        if (we3 && (int'(a3) < PC))
            busy_next[a3] = 1'b0;
        // Applied after the clear so a same-cycle issue to the written register wins.
        if (issue && (int'(issue_a) < PC))
            busy_next[issue_a] = 1'b1;
        busy_next[PC] = 1'b0;
        for (int i = 0; i < NREG; i++)
            cnt_next = cnt_next + (AW + 1)'(busy_next[i]);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_next;
            pend_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with PC slot, NRD combinational read ports and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = DEF_NREG,
    parameter int NRD   = DEF_NRD,
    localparam int AW   = clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NRD*AW-1:0]  a_rd,
    input  logic [NRD-1:0]     re,
    output logic [NRD*WIDTH-1:0] rd,
    input  logic               we3,
    input  logic [AW-1:0]      a3,
    input  logic [WIDTH-1:0]   wd3,
    input  logic [WIDTH-1:0]   r15,
    input  logic               issue,
    input  logic [AW-1:0]      issue_a,
    output logic [NRD-1:0]     rd_busy,
    output logic               stall,
    output logic [AW:0]        pend_cnt
);

    localparam int PC = pc_slot(NREG);

    logic [WIDTH-1:0] mem [PC];
    logic [NREG-1:0]  busy;
    logic             wr_ok;

    assign wr_ok = we3 && (int'(a3) < PC);

    // NOTE: storage is cleared by the async reset so reads return 0 immediately after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PC; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[a3] <= wd3;
        end
    end

    regfile_scoreboard #(.NREG(NREG)) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .we3      (we3),
        .a3       (a3),
        .issue    (issue),
        .issue_a  (issue_a),
        .busy     (busy),
        .pend_cnt (pend_cnt)
    );

    always_comb begin
        logic [AW-1:0] addr;
        addr    = '0;
        rd      = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            addr = a_rd[k*AW +: AW];
            if (int'(addr) == PC) begin
                rd[k*WIDTH +: WIDTH] = r15;
            end else if (int'(addr) < PC) begin
                rd[k*WIDTH +: WIDTH] = mem[addr];
                rd_busy[k]           = busy[addr];
`ifdef REGFILE_BYPASS_EN
                // Reset gates forwarding so every output reads 0 while rst_n is low.
                if (rst_n && wr_ok && (addr == a3)) begin
                    rd[k*WIDTH +: WIDTH] = wd3;
                    if (!(issue && (issue_a == a3)))
                        rd_busy[k] = 1'b0;
                end
`endif
            end
        end
    end

    assign stall = |(re & rd_busy);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with a behavioural model checked every negedge.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int W = 32;
    localparam int N = 16;
    localparam int P = 3;
    localparam int A = 4;

    logic           clk, rst_n;
    logic [P*A-1:0] a_rd;
    logic [P-1:0]   re;
    logic [P*W-1:0] rd;
    logic           we3;
    logic [A-1:0]   a3;
    logic [W-1:0]   wd3;
    logic [W-1:0]   r15;
    logic           issue;
    logic [A-1:0]   issue_a;
    logic [P-1:0]   rd_busy;
    logic           stall;
    logic [A:0]     pend_cnt;

    int total = 0;
    int bad   = 0;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .a_rd(a_rd), .re(re), .rd(rd),
        .we3(we3), .a3(a3), .wd3(wd3), .r15(r15), .issue(issue),
        .issue_a(issue_a), .rd_busy(rd_busy), .stall(stall), .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: architectural contents and the set of pending registers.
    logic [W-1:0] m_mem  [N];
    bit           m_busy [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we3 && a3 != 4'(N - 1)) begin
                m_mem[a3]  = wd3;
                m_busy[a3] = 1'b0;
            end
            if (issue && issue_a != 4'(N - 1))
                m_busy[issue_a] = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [P*W-1:0] e_rd;
        logic [P-1:0]   e_busy;
        int             cnt;
        logic [A-1:0]   ad;
        e_rd   = '0;
        e_busy = '0;
        cnt    = 0;
        for (int k = 0; k < P; k++) begin
            ad = a_rd[k*A +: A];
            if (ad == 4'(N - 1)) begin
                e_rd[k*W +: W] = r15;
            end else begin
                e_rd[k*W +: W] = m_mem[ad];
                e_busy[k]      = m_busy[ad];
`ifdef REGFILE_BYPASS_EN
                if (rst_n && we3 && ad == a3) begin
                    e_rd[k*W +: W] = wd3;
                    if (!(issue && issue_a == a3)) e_busy[k] = 1'b0;
                end
`endif
            end
        end
        for (int i = 0; i < N; i++) cnt += int'(m_busy[i]);
        check("model_rd", 128'(rd), 128'(e_rd));
        check("model_rd_busy", 128'(rd_busy), 128'(e_busy));
        check("model_stall", 128'(stall), 128'(|(re & e_busy)));
        check("model_pend", 128'(pend_cnt), 128'(cnt));
    end

    function automatic logic [P*A-1:0] pk(input int p0, input int p1, input int p2);
        return {4'(p2), 4'(p1), 4'(p0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we3   = 1'b0;
        issue = 1'b0;
    endtask

    typedef struct {
        logic       we;
        int         wa;
        logic [W-1:0] wd;
        logic       is;
        int         ia;
        int         r0, r1, r2;
        logic [P-1:0] rm;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 6,  32'h0000_0066, 1'b1, 8,  6, 8, 15, 3'b010};
        vecs[1] = '{1'b1, 8,  32'h0000_0088, 1'b1, 9,  8, 9, 6,  3'b011};
        vecs[2] = '{1'b0, 0,  32'h0,         1'b1, 9,  9, 9, 9,  3'b100};
        vecs[3] = '{1'b1, 15, 32'hFFFF_FFFF, 1'b1, 15, 15, 9, 0, 3'b111};
        vecs[4] = '{1'b1, 9,  32'h0000_0099, 1'b1, 10, 9, 10, 6, 3'b111};
        vecs[5] = '{1'b1, 10, 32'h0000_00AA, 1'b1, 10, 10, 10, 10, 3'b001};
        vecs[6] = '{1'b1, 10, 32'h0000_00AB, 1'b0, 0,  10, 0, 14, 3'b111};
        vecs[7] = '{1'b1, 0,  32'hCAFE_0000, 1'b0, 0,  0, 10, 8, 3'b000};

        rst_n   = 1'b0;
        a_rd    = '0;
        re      = '0;
        r15     = 32'h0000_0108;
        // Activity during reset must be dropped.
        we3     = 1'b1;
        a3      = 4'd3;
        wd3     = 32'hFFFF_0000;
        issue   = 1'b1;
        issue_a = 4'd3;
        #12;
        check("reset_rd", 128'(rd), 128'(0));
        check("reset_pend", 128'(pend_cnt), 128'(0));
        check("reset_busy", 128'(rd_busy), 128'(0));
        idle();
        rst_n = 1'b1;
        step();

        // Write then read back.
        we3 = 1'b1; a3 = 4'd3; wd3 = 32'hDEAD_BEEF; a_rd = pk(3, 0, 0);
        step();
        idle();
        check("r3_readback", 128'(rd[W-1:0]), 128'(32'hDEAD_BEEF));

        // Writes to the PC slot are ignored; all ports return R15.
        we3 = 1'b1; a3 = 4'd15; wd3 = 32'h55; a_rd = pk(15, 15, 15);
        step();
        idle();
        check("r15_all", 128'(rd), 128'({3{32'h0000_0108}}));
        check("r15_pend", 128'(pend_cnt), 128'(0));
        a_rd = pk(3, 14, 0);
        #1;
        check("r15_no_store", 128'(rd), 128'({32'h0, 32'h0, 32'hDEAD_BEEF}));
        step();

        // Issue R5, port 1 watches it.
        issue = 1'b1; issue_a = 4'd5; re = 3'b010; a_rd = pk(0, 5, 0);
        step();
        idle();
        check("r5_busy", 128'(rd_busy[1]), 128'(1));
        check("r5_stall", 128'(stall), 128'(1));
        check("r5_pend1", 128'(pend_cnt), 128'(1));
        we3 = 1'b1; a3 = 4'd5; wd3 = 32'h5555;
        step();
        idle();
        check("r5_stall_clr", 128'(stall), 128'(0));
        check("r5_pend0", 128'(pend_cnt), 128'(0));

        // Same-cycle issue and write: set wins.
        issue = 1'b1; issue_a = 4'd7; we3 = 1'b1; a3 = 4'd7; wd3 = 32'h77; a_rd = pk(7, 0, 0);
        step();
        idle();
        check("r7_busy", 128'(rd_busy[0]), 128'(1));
        check("r7_pend", 128'(pend_cnt), 128'(1));
        check("r7_data", 128'(rd[W-1:0]), 128'(32'h77));
        we3 = 1'b1; a3 = 4'd7; wd3 = 32'h78;
        step();
        idle();
        check("r7_cleared", 128'(pend_cnt), 128'(0));

        // Same-cycle read of a register being written.
        we3 = 1'b1; a3 = 4'd2; wd3 = 32'h1111; a_rd = pk(0, 0, 2);
        step();
        we3 = 1'b1; a3 = 4'd2; wd3 = 32'h1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("r2_same_cycle", 128'(rd[2*W +: W]), 128'(32'h1234));
`else
        check("r2_same_cycle", 128'(rd[2*W +: W]), 128'(32'h1111));
`endif
        step();
        idle();
        check("r2_next_cycle", 128'(rd[2*W +: W]), 128'(32'h1234));

        // Duplicate issue counts once; issue to the PC slot is ignored.
        issue = 1'b1; issue_a = 4'd9;
        step();
        step();
        issue_a = 4'd15;
        step();
        idle();
        check("dup_issue_pend", 128'(pend_cnt), 128'(1));
        we3 = 1'b1; a3 = 4'd9; wd3 = 32'h9;
        step();
        idle();

        // Directed table exercised through the model.
        foreach (vecs[i]) begin
            we3 = vecs[i].we; a3 = 4'(vecs[i].wa); wd3 = vecs[i].wd;
            issue = vecs[i].is; issue_a = 4'(vecs[i].ia);
            a_rd = pk(vecs[i].r0, vecs[i].r1, vecs[i].r2); re = vecs[i].rm;
            step();
        end
        idle();
        // Busy after table: 8 (issued in vec0, written in vec1) cleared, 9 cleared, 10 cleared -> none.
        check("table_pend", 128'(pend_cnt), 128'(0));
        check("table_r0", 128'(rd[W-1:0]), 128'(32'hCAFE_0000));

        // Issue R1, R2, R4 then pulse reset between edges.
        a_rd = pk(1, 2, 4); re = 3'b111;
        issue = 1'b1; issue_a = 4'd1; step();
        issue_a = 4'd2; step();
        issue_a = 4'd4; step();
        idle();
        check("pre_rst_pend", 128'(pend_cnt), 128'(3));
        check("pre_rst_busy", 128'(rd_busy), 128'(3'b111));
        check("pre_rst_stall", 128'(stall), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rd", 128'(rd), 128'(0));
        check("async_busy", 128'(rd_busy), 128'(0));
        check("async_stall", 128'(stall), 128'(0));
        check("async_pend", 128'(pend_cnt), 128'(0));
        rst_n = 1'b1;
        a_rd = pk(3, 2, 0);
        step();
        check("post_rst_pend", 128'(pend_cnt), 128'(0));
        check("post_rst_r3", 128'(rd), 128'(0));
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
